oled_frame_streamer: RTL and testbench

Pushes one full frame to the 96x64 SSD1331 PmodOLED over its 4-wire SPI link. Acts as the pixel-scan initiator: drives the `x`/`y` coordinates that the game-screen blocks decode and samples their `oled_data` colour in return. Each frame begins with a short address-window command burst. The RGB565 words then stream out MSB-first. Sits between the screen multiplexer and the Pmod pins.

---
 rtl/oled_pkg.sv | 54 +++++
 rtl/oled_spi_shifter.sv | 64 ++++++
 rtl/oled_frame_streamer.sv | 167 ++++++++++++++++
 tb/tb_oled_frame_streamer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// ----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the SSD1331 PmodOLED frame path: panel geometry,
// address-window command opcodes, frame FSM states, SPI word sizes and the
// RGB565 palette used by the screen blocks.
// ----------------------------------------------------------------------------
package oled_pkg;

    localparam int unsigned OLED_WIDTH  = 96;
    localparam int unsigned OLED_HEIGHT = 64;

    localparam logic [7:0] CMD_SET_COL = 8'h15;
    localparam logic [7:0] CMD_SET_ROW = 8'h75;

    localparam int unsigned CMD_BYTES = 6;
    localparam logic [4:0]  CMD_NBITS = 5'd8;
    localparam logic [4:0]  PIX_NBITS = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        PIX,
        DONE
    } oled_state_t;

    // RGB565 palette
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;
    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;

    // Address-window burst: column range 0..last_col, then row range 0..last_row.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                            input logic [7:0] last_col,
                                            input logic [7:0] last_row);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = CMD_SET_COL;
            3'd1:    b = 8'h00;
            3'd2:    b = last_col;
            3'd3:    b = CMD_SET_ROW;
            3'd4:    b = 8'h00;
            3'd5:    b = last_row;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// ----------------------------------------------------------------------------
// oled_spi_shifter
// MSB-first SPI serializer, two clk cycles per bit: phase A drives sclk low
// with the new bit on sdin, phase B raises sclk for the display to sample.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : start a new word (takes priority; may coincide with o_last)
//   i_word         : word to send; 8-bit words use the low byte
//   i_nbits        : word length, 8 or 16
//   o_sclk, o_sdin : registered SPI pins
//   o_last         : high in the final cycle (phase B of the last bit) of a word
// ----------------------------------------------------------------------------
module oled_spi_shifter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [15:0] i_word,
    input  logic [4:0]  i_nbits,
    output logic        o_sclk,
    output logic        o_sdin,
    output logic        o_last
);
    logic [15:0] r_shift;
    logic [3:0]  r_cnt;
    logic        r_phase;
    logic        r_active;
    logic        r_sclk;

    assign o_last = r_active & r_phase & (r_cnt == '0);
    assign o_sclk = r_sclk;
    // Current bit always sits in the top position, so sdin is a register bit.
    assign o_sdin = r_shift[15];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_active <= 1'b0;
            r_sclk   <= 1'b1;
        end else if (i_load) begin
            r_shift  <= (i_nbits == 5'd8) ? {i_word[7:0], 8'h00} : i_word;
            r_cnt    <= 4'(i_nbits - 5'd1);
            r_phase  <= 1'b0;
            r_active <= 1'b1;
            r_sclk   <= 1'b0;
        end else if (r_active) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
                r_sclk  <= 1'b1;
            end else if (r_cnt == '0) begin
                // End of word with nothing queued: park with sclk high and
                // sdin held, so sdin never moves while sclk is high.
                r_phase  <= 1'b0;
                r_active <= 1'b0;
            end else begin
                r_phase <= 1'b0;
                r_sclk  <= 1'b0;
                r_shift <= {r_shift[14:0], 1'b0};
                r_cnt   <= r_cnt - 4'd1;
            end
        end
    end

endmodule

// File: rtl/oled_frame_streamer.sv
// ----------------------------------------------------------------------------
// oled_frame_streamer
// Streams one full frame to the SSD1331 over 4-wire SPI: a 6-byte
// address-window command burst (dc=0) followed by WIDTH*HEIGHT RGB565 words
// (dc=1), row-major. Drives x/y to the screen blocks and samples oled_data
// when each word is loaded.
//   i_clk, i_rst_n      : clock (also the SPI bit clock source), async reset
//   i_start             : one-cycle frame request, honoured only in IDLE
//   i_oled_data         : colour for the pixel at o_x/o_y
//   o_x, o_y            : next pixel to fetch
//   o_cs_n, o_sclk,
//   o_sdin, o_dc        : SPI pins (all registered)
//   o_busy              : frame in progress (CMD or PIX)
//   o_frame_done        : one-cycle pulse in the cycle after the last bit
// ----------------------------------------------------------------------------
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter int unsigned WIDTH  = OLED_WIDTH,
    parameter int unsigned HEIGHT = OLED_HEIGHT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_oled_data,
    output logic [6:0]  o_x,
    output logic [5:0]  o_y,
    output logic        o_cs_n,
    output logic        o_sclk,
    output logic        o_sdin,
    output logic        o_dc,
    output logic        o_busy,
    output logic        o_frame_done
);
    localparam logic [6:0] X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0] Y_LAST   = 6'(HEIGHT - 1);
    localparam logic [7:0] COL_LAST = 8'(WIDTH - 1);
    localparam logic [7:0] ROW_LAST = 8'(HEIGHT - 1);
    localparam logic [2:0] CMD_LAST = 3'(CMD_BYTES - 1);

    oled_state_t r_state;
    oled_state_t w_next;

    logic [2:0]  r_cmd_idx;
    logic [2:0]  w_cmd_idx_nxt;
    logic [6:0]  r_x;
    logic [5:0]  r_y;
    logic        r_cs_n;
    logic        r_dc;
    logic        r_busy;
    logic        r_frame_done;

    logic        w_load;
    logic [15:0] w_word;
    logic [4:0]  w_nbits;
    logic        w_advance;
    logic        w_last;
    logic        w_frame_end;
    logic        w_active_next;

    // x/y only return to the origin once the final pixel has been loaded,
    // so reaching the end of a word in PIX with x/y at (0,0) ends the frame.
    assign w_frame_end   = (r_x == '0) && (r_y == '0);
    assign w_active_next = (w_next == CMD) || (w_next == PIX);

    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_word        = '0;
        w_nbits       = CMD_NBITS;
        w_advance     = 1'b0;
        w_cmd_idx_nxt = r_cmd_idx;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next        = CMD;
                    w_load        = 1'b1;
                    w_cmd_idx_nxt = '0;
                    w_word        = {8'h00, cmd_byte(3'd0, COL_LAST, ROW_LAST)};
                end
            end
            CMD: begin
                if (w_last) begin
                    w_load = 1'b1;
                    if (r_cmd_idx == CMD_LAST) begin
                        w_next    = PIX;
                        w_word    = i_oled_data;
                        w_nbits   = PIX_NBITS;
                        w_advance = 1'b1;
                    end else begin
                        w_cmd_idx_nxt = r_cmd_idx + 3'd1;
                        w_word        = {8'h00, cmd_byte(r_cmd_idx + 3'd1, COL_LAST, ROW_LAST)};
                    end
                end
            end
            PIX: begin
                if (w_last) begin
                    if (w_frame_end) begin
                        w_next = DONE;
                    end else begin
                        w_load    = 1'b1;
                        w_word    = i_oled_data;
                        w_nbits   = PIX_NBITS;
                        w_advance = 1'b1;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pin-level status is registered from the next state so it lines up
    // with the state it describes without a combinational path to the pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd_idx    <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_cs_n       <= 1'b1;
            r_dc         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cmd_idx    <= w_cmd_idx_nxt;
            r_cs_n       <= ~w_active_next;
            r_busy       <= w_active_next;
            r_dc         <= (w_next == PIX);
            r_frame_done <= (w_next == DONE);
            if (w_advance) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + 6'd1;
                end else begin
                    r_x <= r_x + 7'd1;
                end
            end
        end
    end

    oled_spi_shifter u_shifter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_word  (w_word),
        .i_nbits (w_nbits),
        .o_sclk  (o_sclk),
        .o_sdin  (o_sdin),
        .o_last  (w_last)
    );

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_cs_n       = r_cs_n;
    assign o_dc         = r_dc;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// ----------------------------------------------------------------------------
// tb_oled_frame_streamer
// Self-checking bench for oled_frame_streamer using a reduced 12x5 panel.
// A monitor decodes the SPI stream into command bytes / pixel words; the
// expected stream is built from the frame rules directly.
// ----------------------------------------------------------------------------
module tb_oled_frame_streamer;

    localparam int TW       = 12;
    localparam int TH       = 5;
    localparam int NPIX     = TW * TH;
    localparam int DONE_OFF = 97 + 32 * NPIX;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] oled_data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        cs_n, sclk, sdin, dc, busy, frame_done;

    always #5 clk = ~clk;

    oled_frame_streamer #(.WIDTH(TW), .HEIGHT(TH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_oled_data  (oled_data),
        .o_x          (x),
        .o_y          (y),
        .o_cs_n       (cs_n),
        .o_sclk       (sclk),
        .o_sdin       (sdin),
        .o_dc         (dc),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Screen model: 0 = constant magenta, 1 = {x,y,000}, 2 = random image
    int          mode = 0;
    logic [15:0] img [NPIX];

    function automatic logic [15:0] screen(input int m, input logic [6:0] xx, input logic [5:0] yy);
        int idx;
        idx = int'(yy) * TW + int'(xx);
        if (m == 0) return 16'hF81F;
        if (m == 1) return {xx, yy, 3'b000};
        if (idx < NPIX) return img[idx];
        return 16'hDEAD;
    endfunction

    always_comb oled_data = screen(mode, x, y);

    // Expected word n of a frame, from the row-major rule.
    function automatic logic [15:0] exp_word(input int m, input int n);
        if (m == 0) return 16'hF81F;
        if (m == 1) return {7'(n % TW), 6'(n / TW), 3'b000};
        return img[n];
    endfunction

    // ---------------- SPI monitor ----------------
    logic [7:0]  cmd_q [$];
    logic [15:0] pix_q [$];
    int          fd_q [$];
    logic [15:0] acc = '0;
    int          nb = 0;
    int          sdin_viol = 0, idle_viol = 0, cs_viol = 0;
    logic        p_sdin = 1'b0, p_rst = 1'b0;

    always @(negedge clk) begin
        if (rst_n && p_rst && (sdin !== p_sdin) && (sclk !== 1'b0)) sdin_viol++;
        p_sdin = sdin;
        p_rst  = rst_n;
        if (busy !== ~cs_n) cs_viol++;
        if (!busy && sclk !== 1'b1) idle_viol++;
        if (frame_done) fd_q.push_back(cyc);
        if (cs_n) begin
            nb = 0;
        end else if (sclk) begin
            acc = {acc[14:0], sdin};
            nb++;
            if (!dc && nb == 8) begin
                cmd_q.push_back(acc[7:0]);
                nb = 0;
            end else if (dc && nb == 16) begin
                pix_q.push_back(acc);
                nb = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_at(input int c);
        wait_cyc(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        cmd_q.delete();
        pix_q.delete();
        fd_q.delete();
    endtask

    task automatic check_stream(input int m, input int nf, input string tag);
        logic [7:0] eb [6];
        eb[0] = 8'h15; eb[1] = 8'h00; eb[2] = 8'(TW - 1);
        eb[3] = 8'h75; eb[4] = 8'h00; eb[5] = 8'(TH - 1);
        chk({tag, " cmd count"}, 32'(cmd_q.size()), 32'(6 * nf));
        for (int i = 0; i < cmd_q.size() && i < 6 * nf; i++)
            chk($sformatf("%s cmd byte %0d", tag, i), 32'(cmd_q[i]), 32'(eb[i % 6]));
        chk({tag, " pixel count"}, 32'(pix_q.size()), 32'(NPIX * nf));
        for (int i = 0; i < pix_q.size() && i < NPIX * nf; i++)
            chk($sformatf("%s pixel %0d", tag, i), 32'(pix_q[i]), 32'(exp_word(m, i % NPIX)));
    endtask

    // Probe table: {cs_n, sclk, sdin, dc, busy, frame_done} at offsets from start
    typedef struct {
        int         off;
        logic [5:0] exp;
        logic [5:0] mask;
        string      name;
    } probe_t;
    probe_t probes [11];

    task automatic run_frame(input int m, input string tag, input bit use_table);
        int s;
        clear_mon();
        mode = m;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        if (use_table) begin
            for (int i = 0; i < 11; i++) begin
                wait_cyc(s + probes[i].off);
                chk({tag, " ", probes[i].name},
                    32'({cs_n, sclk, sdin, dc, busy, frame_done} & probes[i].mask),
                    32'(probes[i].exp & probes[i].mask));
            end
        end
        wait_cyc(s + DONE_OFF + 2);
        check_stream(m, 1, tag);
        chk({tag, " frame_done count"}, 32'(fd_q.size()), 32'd1);
        if (fd_q.size() > 0) chk({tag, " frame_done cycle"}, 32'(fd_q[0]), 32'(s + DONE_OFF));
        chk({tag, " x after done"}, 32'(x), 32'd0);
        chk({tag, " y after done"}, 32'(y), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests + 1, failed + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] row_last;
        int s;
        row_last = 8'(TH - 1);
        probes[0]  = '{1,            6'b000010, 6'b111111, "cmd byte0 bit7 A"};
        probes[1]  = '{2,            6'b010010, 6'b111111, "cmd byte0 bit7 B"};
        probes[2]  = '{7,            6'b001010, 6'b111111, "cmd byte0 bit4 A"};
        probes[3]  = '{16,           6'b011010, 6'b111111, "cmd byte0 bit0 B"};
        probes[4]  = '{17,           6'b000010, 6'b111111, "cmd byte1 bit7 A"};
        probes[5]  = '{96,           {2'b01, row_last[0], 3'b010}, 6'b111111, "cmd last cycle"};
        probes[6]  = '{97,           6'b001110, 6'b111111, "pixel0 MSB A"};
        probes[7]  = '{98,           6'b011110, 6'b111111, "pixel0 MSB B"};
        probes[8]  = '{DONE_OFF - 1, 6'b011110, 6'b111111, "last pixel last bit"};
        probes[9]  = '{DONE_OFF,     6'b110001, 6'b110011, "done cycle"};
        probes[10] = '{DONE_OFF + 1, 6'b110000, 6'b110011, "idle after done"};
        for (int i = 0; i < NPIX; i++) img[i] = 16'($urandom);

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("in reset outputs", 32'({cs_n, sclk, sdin, dc, busy, frame_done, x, y}),
            32'({6'b110000, 13'd0}));
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle outputs", 32'({cs_n, sclk, sdin, dc, busy, frame_done, x, y}),
                32'({6'b110000, 13'd0}));
        end

        run_frame(0, "const", 1'b1);
        run_frame(1, "xy", 1'b0);
        run_frame(2, "rand", 1'b0);

        // Extra start pulses during a frame and in DONE are ignored.
        clear_mon();
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        pulse_at(s + 50);
        pulse_at(s + 500);
        pulse_at(s + DONE_OFF);
        pulse_at(s + DONE_OFF + 1);
        wait_cyc(s + 2 * DONE_OFF + 3);
        chk("pulses frame_done count", 32'(fd_q.size()), 32'd2);
        if (fd_q.size() > 0) chk("pulses first done", 32'(fd_q[0]), 32'(s + DONE_OFF));
        if (fd_q.size() > 1) chk("pulses second done", 32'(fd_q[1]), 32'(s + 2 * DONE_OFF + 1));
        check_stream(0, 2, "pulses");

        // Asynchronous reset in the middle of the pixel stream.
        clear_mon();
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 501);
        chk("pre-reset sclk low", 32'({sclk, cs_n, busy}), 32'(3'b001));
        #1 rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({cs_n, sclk, sdin, dc, busy, frame_done, x, y}),
            32'({6'b110000, 13'd0}));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(cyc + DONE_OFF + 5);
        chk("aborted frame_done count", 32'(fd_q.size()), 32'd0);
        run_frame(1, "restart", 1'b0);

        chk("sdin moved while sclk high", 32'(sdin_viol), 32'd0);
        chk("sclk low while not busy", 32'(idle_viol), 32'd0);
        chk("cs_n vs busy", 32'(cs_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
